fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, 4, number of write requesters (2..8).
REQ-002 Parameter FIFO_WIDTH, 32, data width; matches the FIFO write port.
REQ-003 Parameter MAX_BURST, 4, maximum beats per grant (1..16).
REQ-004 Port clk  input  1  write-domain clock; one clock only; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 Port req_last  input  NUM_REQ  per-requester final beat of packet.
REQ-008 Port req_data  input  NUM_REQ x FIFO_WIDTH  per-requester beat data.
REQ-009 Port req_ready  output  NUM_REQ  per-requester beat accepted; one-hot or zero.
REQ-010 Port full  input  1  FIFO full flag, write-domain, already synchronised.
REQ-011 Port wr_en  output  1  FIFO write enable.
REQ-012 Port wr_data  output  FIFO_WIDTH  FIFO write data.
REQ-013 Port grant_id  output  clog2(NUM_REQ)  index of the current grant holder.
REQ-014 Port busy  output  1  high while a grant is held.

Function
REQ-015 Two states, IDLE and GRANT, in a registered FSM.
REQ-016 IDLE: when any req_valid is high, the block registers the round-robin winner into grant_id, clears the beat counter and enters GRANT on the next edge; no transfer occurs in IDLE.
REQ-017 Round-robin search starts at index rr_ptr and wraps modulo NUM_REQ; the lowest index at or above rr_ptr with req_valid high wins.
REQ-018 GRANT: req_ready[grant_id] = !full; all other req_ready bits are 0.
REQ-019 GRANT: wr_en = req_valid[grant_id] && !full; wr_data = req_data[grant_id]; both combinational. In IDLE, wr_en = 0 and wr_data = 0.
REQ-020 A beat transfers in a cycle where wr_en = 1; the beat counter (clog2(MAX_BURST)+1 bits) increments only on a transfer.
REQ-021 Release: on a transfer with req_last[grant_id] = 1, or on the transfer that makes the count equal MAX_BURST, return to IDLE and set rr_ptr = (grant_id + 1) mod NUM_REQ.
REQ-022 While full = 1, no transfer occurs, the counter holds and the grant holds.
REQ-023 If the grant holder drops req_valid mid-packet, the grant holds until release; other requesters wait.
REQ-024 Latency: a request arriving in IDLE at cycle N allows its first transfer at cycle N+1 at the earliest; each release costs one IDLE cycle before the next grant.
REQ-025 A request that appears in the same cycle as another's release is arbitrated in the following IDLE cycle, using the updated rr_ptr.
REQ-026 A packet longer than MAX_BURST is split; the requester re-arbitrates for the remainder.
REQ-027 busy = 1 exactly when the state is GRANT.

Reset
REQ-028 With rst = 1 at an edge: state = IDLE, rr_ptr = 0, grant_id = 0 and counter = 0; consequently busy = 0, wr_en = 0, req_ready = 0 and wr_data = 0.
REQ-029 Reset asserted mid-burst abandons the burst; no wr_en occurs in the cycle after the reset edge. Untransferred beats are the requester's responsibility.

Structure
REQ-030 Package fifo_arb_pkg holds the state enum typedef (IDLE, GRANT) and the NUM_REQ and MAX_BURST default constants.
REQ-031 The round-robin winner selection is a combinational sub-module rr_pick with inputs req and ptr and outputs winner index and any_req; the FSM, counter and muxes live in fifo_wr_arb.

Verification
REQ-032 Reset: rst high 2 cycles with all req_valid high -> wr_en = 0, req_ready = 0, busy = 0 throughout; the first grant after reset goes to index 0.
REQ-033 Round-robin: requesters 0..3 all hold single-beat packets (last = 1) -> grants in order 0, 1, 2, 3, 0, with one IDLE cycle between each grant.
REQ-034 Burst cap: MAX_BURST = 4 and requester 1 sends a 6-beat packet while requester 2 is waiting -> 4 beats from requester 1, then requester 2, then the last 2 beats of requester 1.
REQ-035 Backpressure: full = 1 for 3 cycles mid-burst -> wr_en = 0 and req_ready = 0 during those cycles, the counter holds, and the burst resumes with no lost or duplicated beats (data 0xA0..0xA3 in order).
REQ-036 Reset mid-burst: rst pulsed after beat 2 of 4 -> next cycle wr_en = 0 and state IDLE; the subsequent grant starts from index 0.
REQ-037 Valid gap: the grant holder drops req_valid for 2 cycles mid-packet while another requester waits -> the grant is held, with no wr_en during the gap.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    // cand[k] is the requester index sitting k places after ptr
    logic [W-1:0] cand [N];
    logic [N-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            assign cand[gi] = W'((int'(ptr) + gi) % N);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    assign any_req = |hit;

    // Scan from the far end so the nearest hit to ptr is the one left standing
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that lets one requester at a time burst beats into a FIFO write port.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int FIFO_WIDTH = 32,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic                                full,
    output logic                                wr_en,
    output logic [FIFO_WIDTH-1:0]               wr_data,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id,
    output logic                                busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    state_t            state_reg,  state_next;
    logic [ID_W-1:0]   grant_reg,  grant_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic [ID_W-1:0]   winner;
    logic              any_req;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        cnt_next    = cnt_reg;
        req_ready   = '0;
        wr_en       = 1'b0;
        wr_data     = '0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next = winner;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_reg] = !full;
                wr_en   = req_valid[grant_reg] && !full;
                wr_data = req_data[grant_reg];
                if (wr_en) begin
                    cnt_next = cnt_inc;
                    // Release at packet end or burst cap; a capped packet re-arbitrates for the rest
                    if (req_last[grant_reg] || (cnt_inc == CNT_MAX)) begin
                        state_next  = IDLE;
                        rr_ptr_next = (grant_reg == LAST_ID) ? '0 : grant_reg + ID_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign grant_id = grant_reg;
    assign busy     = (state_reg == GRANT);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed, table-driven bench for fifo_wr_arb with four requesters and a burst cap of four.
module tb_fifo_wr_arb;

    localparam int NR = 4;
    localparam int FW = 32;

    logic                   clk;
    logic                   rst;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_last;
    logic [NR-1:0][FW-1:0]  req_data;
    logic [NR-1:0]          req_ready;
    logic                   full;
    logic                   wr_en;
    logic [FW-1:0]          wr_data;
    logic [1:0]             grant_id;
    logic                   busy;

    fifo_wr_arb #(
        .NUM_REQ    (NR),
        .FIFO_WIDTH (FW),
        .MAX_BURST  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [7:0]  dat;
        logic        x_wr;
        logic [3:0]  x_rdy;
        logic        x_busy;
        logic [1:0]  x_gid;
        logic [31:0] x_wdata;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic f, logic [7:0] d,
                                logic xw, logic [3:0] xr, logic xb, logic [1:0] xg, logic [31:0] xd);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.full = f; t.dat = d;
        t.x_wr = xw; t.x_rdy = xr; t.x_busy = xb; t.x_gid = xg; t.x_wdata = xd;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        rst       = t.rst;
        req_valid = t.valid;
        req_last  = t.last;
        full      = t.full;
        for (int i = 0; i < NR; i++) req_data[i] = {16'h0, 8'(i), t.dat};
    endtask

    initial begin
        // reset held with every requester asking
        vq.push_back(mk(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(1, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 0, 32'h0));
        // round robin over single-beat packets: 0,1,2,3,0
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 1, 4'b0001, 1, 0, 32'h010));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 1, 4'b0010, 1, 1, 32'h110));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 1, 32'h0));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 1, 4'b0100, 1, 2, 32'h210));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 2, 32'h0));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 1, 4'b1000, 1, 3, 32'h310));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 0, 4'b0000, 0, 3, 32'h0));
        vq.push_back(mk(0, 4'hF, 4'hF, 0, 8'h10, 1, 4'b0001, 1, 0, 32'h010));
        vq.push_back(mk(0, 4'h0, 4'h0, 0, 8'h10, 0, 4'b0000, 0, 0, 32'h0));
        // burst cap: req 1 six beats, req 2 waiting
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h20, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h20, 1, 4'b0010, 1, 1, 32'h120));
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h21, 1, 4'b0010, 1, 1, 32'h121));
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h22, 1, 4'b0010, 1, 1, 32'h122));
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h23, 1, 4'b0010, 1, 1, 32'h123));
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h24, 0, 4'b0000, 0, 1, 32'h0));
        vq.push_back(mk(0, 4'b0110, 4'b0100, 0, 8'h24, 1, 4'b0100, 1, 2, 32'h224));
        vq.push_back(mk(0, 4'b0010, 4'b0000, 0, 8'h24, 0, 4'b0000, 0, 2, 32'h0));
        vq.push_back(mk(0, 4'b0010, 4'b0000, 0, 8'h24, 1, 4'b0010, 1, 1, 32'h124));
        vq.push_back(mk(0, 4'b0010, 4'b0010, 0, 8'h25, 1, 4'b0010, 1, 1, 32'h125));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 8'h25, 0, 4'b0000, 0, 1, 32'h0));
        // backpressure: full for 3 cycles after the first beat of A0..A3
        vq.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'hA0, 0, 4'b0000, 0, 1, 32'h0));
        vq.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'hA0, 1, 4'b0001, 1, 0, 32'h0A0));
        vq.push_back(mk(0, 4'b0001, 4'b0000, 1, 8'hA1, 0, 4'b0000, 1, 0, 32'h0A1));
        vq.push_back(mk(0, 4'b0001, 4'b0000, 1, 8'hA1, 0, 4'b0000, 1, 0, 32'h0A1));
        vq.push_back(mk(0, 4'b0001, 4'b0000, 1, 8'hA1, 0, 4'b0000, 1, 0, 32'h0A1));
        vq.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'hA1, 1, 4'b0001, 1, 0, 32'h0A1));
        vq.push_back(mk(0, 4'b0001, 4'b0000, 0, 8'hA2, 1, 4'b0001, 1, 0, 32'h0A2));
        vq.push_back(mk(0, 4'b0001, 4'b0001, 0, 8'hA3, 1, 4'b0001, 1, 0, 32'h0A3));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 8'hA3, 0, 4'b0000, 0, 0, 32'h0));
        // reset mid-burst on requester 2; the next grant must start from index 0
        vq.push_back(mk(0, 4'b0100, 4'b0000, 0, 8'hB0, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(0, 4'b0100, 4'b0000, 0, 8'hB0, 1, 4'b0100, 1, 2, 32'h2B0));
        vq.push_back(mk(0, 4'b0100, 4'b0000, 0, 8'hB1, 1, 4'b0100, 1, 2, 32'h2B1));
        vq.push_back(mk(1, 4'b0100, 4'b0000, 0, 8'hB2, 1, 4'b0100, 1, 2, 32'h2B2));
        vq.push_back(mk(0, 4'b0111, 4'b0001, 0, 8'hC0, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(0, 4'b0111, 4'b0001, 0, 8'hC0, 1, 4'b0001, 1, 0, 32'h0C0));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 8'hC0, 0, 4'b0000, 0, 0, 32'h0));
        // valid gap on holder 1 while requester 3 waits
        vq.push_back(mk(0, 4'b1010, 4'b0000, 0, 8'hD0, 0, 4'b0000, 0, 0, 32'h0));
        vq.push_back(mk(0, 4'b1010, 4'b0000, 0, 8'hD0, 1, 4'b0010, 1, 1, 32'h1D0));
        vq.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'hD1, 0, 4'b0010, 1, 1, 32'h1D1));
        vq.push_back(mk(0, 4'b1000, 4'b0000, 0, 8'hD1, 0, 4'b0010, 1, 1, 32'h1D1));
        vq.push_back(mk(0, 4'b1010, 4'b0010, 0, 8'hD1, 1, 4'b0010, 1, 1, 32'h1D1));
        vq.push_back(mk(0, 4'b1000, 4'b1000, 0, 8'hD2, 0, 4'b0000, 0, 1, 32'h0));
        vq.push_back(mk(0, 4'b1000, 4'b1000, 0, 8'hD2, 1, 4'b1000, 1, 3, 32'h3D2));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 8'hD2, 0, 4'b0000, 0, 3, 32'h0));

        drive(vq[0]);
        @(posedge clk);
        #1;

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k]);
            @(negedge clk);
            $display("vec %0d: rst=%b valid=%b full=%b -> wr_en=%b ready=%b busy=%b gid=%0d wr_data=%h",
                     k, rst, req_valid, full, wr_en, req_ready, busy, grant_id, wr_data);
            check("wr_en",     k, 32'(wr_en),     32'(vq[k].x_wr));
            check("req_ready", k, 32'(req_ready), 32'(vq[k].x_rdy));
            check("busy",      k, 32'(busy),      32'(vq[k].x_busy));
            check("grant_id",  k, 32'(grant_id),  32'(vq[k].x_gid));
            check("wr_data",   k, wr_data,        vq[k].x_wdata);
            @(posedge clk);
            #1;
        end

        // first-transfer latency from an idle arbiter, bounded wait
        begin
            vec_t t;
            int   lat;
            bit   found;
            t = mk(0, 4'b0100, 4'b0100, 0, 8'hE0, 0, 4'b0000, 0, 0, 32'h0);
            drive(t);
            lat   = 0;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (wr_en) found = 1'b1;
                else       lat++;
            end
            $display("latency seq: found=%b latency=%0d gid=%0d wr_data=%h", found, lat, grant_id, wr_data);
            n_cmp++;
            if (!found) begin
                n_err++;
                $display("FAIL latency_timeout: got no wr_en in 8 cycles, required wr_en");
            end else begin
                check("latency",     0, 32'(lat),      32'd1);
                check("lat_gid",     0, 32'(grant_id), 32'd2);
                check("lat_wr_data", 0, wr_data,       32'h2E0);
            end
            @(posedge clk);
            #1;
            req_valid = '0;
            req_last  = '0;
            @(negedge clk);
            check("post_release_busy", 0, 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
